column_pair_scheduler: RTL and testbench
========================================

# column_pair_scheduler

Sequences the combinational sphere frame generator through all column pairs of one angular slice. Each slice is triggered by a rotation tick. For every scan line the block drives the pair indices, captures the two returned columns into a holding register, and hands them to the HUB75 panel driver over a valid/ready handshake. It sits between the rotation-sensing logic and the frame generator/panel driver.

## Interface
Parameters:
- SCAN_RATE, 32, scan lines per half-panel; column pairs per slice
- NUM_ROWS, 64, pixels per column
- RGB_RES, 9, bits per pixel
- NUM_SLICES, 128, angular slices per revolution

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; one clock; reset is asynchronous and active-high
- slice_tick_in  input  1  one-cycle pulse: new angular slice begins
- column_index1_out  output  $clog2(SCAN_RATE)  first column index to frame generator
- column_index2_out  output  $clog2(SCAN_RATE)+1  second column index to frame generator
- columns_in  input  2×NUM_ROWS×RGB_RES  generator result for the current indices ([0]=index1, [1]=index2)
- columns_out  output  2×NUM_ROWS×RGB_RES  held column pair to the panel driver
- column_valid_out  output  1  columns_out valid
- column_ready_in  input  1  panel driver accepts the pair
- line_addr_out  output  $clog2(SCAN_RATE)  scan line of columns_out
- slice_idx_out  output  $clog2(NUM_SLICES)  current slice number
- busy_out  output  1  slice in progress
- slice_done_out  output  1  one-cycle pulse after the last pair is accepted
- overrun_out  output  1  sticky: a tick arrived while busy

## Operation
- States: IDLE, FETCH, PRESENT.
- IDLE + slice_tick_in:
  - k←0; index1←0, index2←SCAN_RATE.
  - slice_idx_out increments; wraps from NUM_SLICES-1 to 0. The first tick after reset yields 1.
  - go to FETCH.
- FETCH, one cycle:
  - capture columns_in into the holding register; line_addr_out←k.
  - go to PRESENT.
- PRESENT:
  - column_valid_out=1; columns_out and line_addr_out are held stable until handshake.
  - Handshake is valid&ready in the same cycle.
  - Handshake with k<SCAN_RATE-1: k←k+1, index1←k+1, index2←k+1+SCAN_RATE, go to FETCH.
  - Handshake with k=SCAN_RATE-1: pulse slice_done_out next cycle, go to IDLE.
- Index arithmetic: index2 = index1 + SCAN_RATE, computed in $clog2(SCAN_RATE)+1 bits, with no wrap.
- busy_out=1 in FETCH and PRESENT.
- slice_tick_in while busy: overrun_out←1 (sticky until reset). The tick's effect depends on the macro (see Configuration).
- A tick in the same cycle as the final handshake counts as busy (overrun).

## Timing
- Reset values:
  - state IDLE, k=0, index1_out=0, index2_out=SCAN_RATE
  - columns_out=0, column_valid_out=0, line_addr_out=0, slice_idx_out=0
  - busy_out=0, slice_done_out=0, overrun_out=0
- Reset mid-slice returns to IDLE immediately; no partial handshake completes.
- Outputs are registered. Indices change in the cycle a transition to FETCH is taken; columns_in is sampled at the end of FETCH, giving the generator one full cycle.
- Tick in cycle t → busy_out at t+1, column_valid_out at t+2.
- Minimum of 2 cycles per pair; a slice takes at least 2·SCAN_RATE cycles, then 1 cycle in IDLE.
- column_valid_out never drops without a handshake, except on reset or a restart.

## Configuration
- SCHED_OVERRUN_RESTART_EN:
  - Defined: a tick while busy aborts the current slice. It drops valid, sets k←0, increments slice_idx_out, and goes to FETCH next cycle. No slice_done_out is generated for the aborted slice.
  - Undefined: a tick while busy is ignored apart from setting overrun_out; the current slice completes normally.

## Structure
- Shared package sphere_pkg holds:
  - enum sched_state_t {IDLE, FETCH, PRESENT}
  - typedef column_pair_t (2×NUM_ROWS×RGB_RES packed)
  - the default SCAN_RATE/NUM_ROWS/RGB_RES constants, shared with the frame generator
- No sub-module; single FSM plus holding register.

## Test plan
- Reset, one tick, ready tied 1 → 32 pairs with indices (0,32)…(31,63) and line_addr 0…31. Valid first seen at tick+2; slice_done pulses once after 64 cycles; slice_idx=1.
- Ready held 0 for 10 cycles on pair 5 → columns_out and line_addr=5 are stable and valid stays 1; on release, indices advance to (6,38).
- Tick at pair 10:
  - macro undefined → slice finishes at line 31 and overrun_out=1.
  - macro defined → valid drops, indices return to (0,32), slice_idx increments, no done pulse.
- 128 back-to-back slices → slice_idx wraps 127→0.
- Assert rst_in during PRESENT at pair 20 → all outputs at reset values next edge; the next tick restarts at (0,32).

Source files
------------

// File: rtl/sphere_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sphere_pkg
// Summary  : Types and default geometry shared by the sphere frame generator
//            and the column pair scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sphere_pkg;

    localparam int unsigned c_SCAN_RATE  = 32;
    localparam int unsigned c_NUM_ROWS   = 64;
    localparam int unsigned c_RGB_RES    = 9;
    localparam int unsigned c_NUM_SLICES = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } sched_state_t;

    // Element [0] (low half) is the index1 column, [1] the index2 column.
    typedef logic [2*c_NUM_ROWS*c_RGB_RES-1:0] column_pair_t;

endpackage : sphere_pkg
`default_nettype wire

// File: rtl/column_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : column_pair_scheduler
// Summary  : Walks one angular slice through all column pairs, holding each
//            generated pair for the HUB75 driver behind valid/ready.
// Options  : SCHED_OVERRUN_RESTART_EN - a tick while busy restarts the slice
// Revision : 1.0 - initial release
// ============================================================================
module column_pair_scheduler
    import sphere_pkg::*;
#(
    parameter int unsigned SCAN_RATE  = c_SCAN_RATE,
    parameter int unsigned NUM_ROWS   = c_NUM_ROWS,
    parameter int unsigned RGB_RES    = c_RGB_RES,
    parameter int unsigned NUM_SLICES = c_NUM_SLICES
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          slice_tick_in,
    output logic [$clog2(SCAN_RATE)-1:0]  column_index1_out,
    output logic [$clog2(SCAN_RATE):0]    column_index2_out,
    input  logic [2*NUM_ROWS*RGB_RES-1:0] columns_in,
    output logic [2*NUM_ROWS*RGB_RES-1:0] columns_out,
    output logic                          column_valid_out,
    input  logic                          column_ready_in,
    output logic [$clog2(SCAN_RATE)-1:0]  line_addr_out,
    output logic [$clog2(NUM_SLICES)-1:0] slice_idx_out,
    output logic                          busy_out,
    output logic                          slice_done_out,
    output logic                          overrun_out
);

    localparam int unsigned KW = $clog2(SCAN_RATE);
    localparam int unsigned SW = $clog2(NUM_SLICES);
    localparam int unsigned CW = 2*NUM_ROWS*RGB_RES;

    localparam logic [KW-1:0] c_K_LAST     = KW'(SCAN_RATE - 1);
    localparam logic [KW:0]   c_IDX2_BASE  = (KW+1)'(SCAN_RATE);
    localparam logic [SW-1:0] c_SLICE_LAST = SW'(NUM_SLICES - 1);

    sched_state_t  state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW:0]   idx2_q, idx2_d;
    logic [KW-1:0] line_q, line_d;
    logic [CW-1:0] cols_q, cols_d;
    logic [SW-1:0] slice_q, slice_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;

    logic w_busy;
    logic w_hs;
    logic w_last;
    logic w_overrun_tick;
    logic w_restart;
    logic w_start;

    assign w_busy         = (state_q != IDLE);
    assign w_hs           = valid_q & column_ready_in;
    assign w_last         = (k_q == c_K_LAST);
    assign w_overrun_tick = slice_tick_in & w_busy;

`ifdef SCHED_OVERRUN_RESTART_EN
    assign w_restart = w_overrun_tick;
`else
    assign w_restart = 1'b0;
`endif

    assign w_start = ((state_q == IDLE) & slice_tick_in) | w_restart;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (slice_tick_in) state_d = FETCH;
            FETCH:   state_d = PRESENT;
            PRESENT: if (w_hs) state_d = w_last ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
        if (w_restart) begin
            state_d = FETCH;
        end
    end

    always_comb begin
        k_d       = k_q;
        line_d    = line_q;
        cols_d    = cols_q;
        slice_d   = slice_q;
        overrun_d = overrun_q | w_overrun_tick;

        if (w_start) begin
            k_d     = '0;
            slice_d = (slice_q == c_SLICE_LAST) ? '0 : slice_q + 1'b1;
        end else if ((state_q == PRESENT) && w_hs && !w_last) begin
            k_d = k_q + 1'b1;
        end

        // The generator has had the whole FETCH cycle to settle on the indices.
        if ((state_q == FETCH) && !w_restart) begin
            cols_d = columns_in;
            line_d = k_q;
        end

        // A restart that coincides with the final handshake swallows the done pulse.
        done_d  = (state_q == PRESENT) && w_hs && w_last && !w_restart;
        idx2_d  = {1'b0, k_d} + c_IDX2_BASE;
        valid_d = (state_d == PRESENT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            k_q       <= '0;
            idx2_q    <= c_IDX2_BASE;
            line_q    <= '0;
            cols_q    <= '0;
            slice_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            k_q       <= k_d;
            idx2_q    <= idx2_d;
            line_q    <= line_d;
            cols_q    <= cols_d;
            slice_q   <= slice_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign column_index1_out = k_q;
    assign column_index2_out = idx2_q;
    assign columns_out       = cols_q;
    assign column_valid_out  = valid_q;
    assign line_addr_out     = line_q;
    assign slice_idx_out     = slice_q;
    assign busy_out          = busy_q;
    assign slice_done_out    = done_q;
    assign overrun_out       = overrun_q;

endmodule : column_pair_scheduler
`default_nettype wire

// File: tb/tb_column_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_pair_scheduler
// Summary  : Self-checking bench for column_pair_scheduler: directed table,
//            corner sequences and random traffic against a slice-level model.
// Options  : SCHED_OVERRUN_RESTART_EN - selects the restart expectations
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_column_pair_scheduler;
    import sphere_pkg::*;

    localparam int SR = c_SCAN_RATE;
    localparam int NR = c_NUM_ROWS;
    localparam int RB = c_RGB_RES;
    localparam int NS = c_NUM_SLICES;
    localparam int KW = $clog2(SR);
    localparam int SW = $clog2(NS);
    localparam int CW = 2*NR*RB;

`ifdef SCHED_OVERRUN_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          ready = 1'b0;
    logic [KW-1:0] idx1;
    logic [KW:0]   idx2;
    logic [CW-1:0] cols_in;
    logic [CW-1:0] cols_out;
    logic          valid;
    logic [KW-1:0] line;
    logic [SW-1:0] sidx;
    logic          busy;
    logic          done;
    logic          ovr;
    int            salt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    // Stand-in frame generator: every pixel depends on column number and salt.
    function automatic logic [CW/2-1:0] gen_col(input int c, input int s);
        logic [CW/2-1:0] v;
        v = '0;
        for (int r = 0; r < NR; r++) v[r*RB +: RB] = RB'((c*37 + r*5 + s) & 'h1ff);
        return v;
    endfunction

    assign cols_in = {gen_col(int'(idx2), salt), gen_col(int'(idx1), salt)};

    column_pair_scheduler dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .slice_tick_in     (tick),
        .column_index1_out (idx1),
        .column_index2_out (idx2),
        .columns_in        (cols_in),
        .columns_out       (cols_out),
        .column_valid_out  (valid),
        .column_ready_in   (ready),
        .line_addr_out     (line),
        .slice_idx_out     (sidx),
        .busy_out          (busy),
        .slice_done_out    (done),
        .overrun_out       (ovr)
    );

    // Reference model: slice progress as pair number plus fetch/present phase.
    bit           m_busy, m_fetch, m_valid, m_done, m_ovr;
    int           m_k, m_line, m_slice;
    column_pair_t m_cols;

    task automatic model_reset();
        m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0; m_ovr = 0;
        m_k = 0; m_line = 0; m_slice = 0; m_cols = '0;
    endtask

    task automatic model_step();
        bit hs, ot;
        hs = m_valid && ready;
        ot = tick && m_busy;
        m_done = 0;
        if (ot) m_ovr = 1;
        if (ot && RESTART) begin
            m_k = 0; m_slice = (m_slice + 1) % NS; m_fetch = 1; m_valid = 0;
        end else if (!m_busy) begin
            if (tick) begin
                m_k = 0; m_slice = (m_slice + 1) % NS; m_busy = 1; m_fetch = 1;
            end
        end else if (m_fetch) begin
            m_cols = {gen_col(m_k + SR, salt), gen_col(m_k, salt)};
            m_line = m_k; m_fetch = 0; m_valid = 1;
        end else if (hs) begin
            if (m_k == SR - 1) begin
                m_busy = 0; m_valid = 0; m_done = 1;
            end else begin
                m_k = m_k + 1; m_fetch = 1; m_valid = 0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("index1", 64'(idx1), 64'(m_k));
        check("index2", 64'(idx2), 64'(m_k + SR));
        check("valid", 64'(valid), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_busy));
        check("line_addr", 64'(line), 64'(m_line));
        check("slice_idx", 64'(sidx), 64'(m_slice));
        check("slice_done", 64'(done), 64'(m_done));
        check("overrun", 64'(ovr), 64'(m_ovr));
        n_cmp++;
        if (cols_out !== m_cols) begin
            n_bad++;
            $display("FAIL columns: got low64 %h expected low64 %h at %0t",
                     cols_out[63:0], m_cols[63:0], $time);
        end
    endtask

    // Inputs are set at a falling edge; the rising edge acts, the next falling edge checks.
    task automatic step();
        salt = int'($urandom_range(0, 511));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (done === 1'b1) n_done++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b0; ready = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("done_reached", 64'(done === 1'b1), 64'd1);
    endtask

    task automatic run_until_line(input int l, input int budget);
        int n;
        n = 0;
        while (!(valid === 1'b1 && int'(line) == l) && n < budget) begin
            step();
            n++;
        end
        check("line_reached", 64'(valid === 1'b1 && int'(line) == l), 64'd1);
    endtask

    typedef struct {
        bit tick;
        bit ready;
        bit e_busy;
        bit e_valid;
        int e_idx1;
        int e_line;
        bit e_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        int s0;

        tbl[0] = '{1, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 1, 0, 1, 0, 0};
        tbl[4] = '{0, 1, 1, 1, 1, 1, 0};
        tbl[5] = '{0, 0, 1, 1, 1, 1, 0};
        tbl[6] = '{0, 1, 1, 0, 2, 1, 0};
        tbl[7] = '{0, 1, 1, 1, 2, 2, 0};

        // Reset values
        do_reset();
        check("rst_index2", 64'(idx2), 64'(SR));
        check("rst_valid", 64'(valid), 64'd0);

        // Directed table: slice start with ready stalls
        for (int i = 0; i < 8; i++) begin
            tick = tbl[i].tick; ready = tbl[i].ready;
            step();
            check("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
            check("tbl_valid", 64'(valid), 64'(tbl[i].e_valid));
            check("tbl_index1", 64'(idx1), 64'(tbl[i].e_idx1));
            check("tbl_line", 64'(line), 64'(tbl[i].e_line));
            check("tbl_done", 64'(done), 64'(tbl[i].e_done));
        end
        tick = 0; ready = 1;
        run_until_done(200, n);

        // Full slice with ready tied high: latency and done timing
        do_reset();
        n_done = 0;
        tick = 1; ready = 1;
        step();
        tick = 0;
        check("tick_busy", 64'(busy), 64'd1);
        check("tick_valid_early", 64'(valid), 64'd0);
        step();
        check("valid_at_t2", 64'(valid), 64'd1);
        run_until_done(200, n);
        check("done_cycle", 64'(n + 2), 64'(2*SR + 1));
        check("done_count", 64'(n_done), 64'd1);
        check("slice_after_one", 64'(sidx), 64'd1);
        step();
        check("done_one_cycle", 64'(done), 64'd0);

        // Back-pressure on pair 5
        tick = 1; ready = 1;
        step();
        tick = 0;
        run_until_line(5, 100);
        ready = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_line", 64'(line), 64'd5);
            check("stall_valid", 64'(valid), 64'd1);
        end
        ready = 1;
        step();
        check("release_index1", 64'(idx1), 64'd6);
        check("release_index2", 64'(idx2), 64'(6 + SR));
        run_until_done(200, n);

        // Tick while busy at pair 10
        n_done = 0;
        s0 = int'(sidx);
        tick = 1; ready = 1;
        step();
        tick = 0;
        run_until_line(10, 100);
        tick = 1;
        step();
        tick = 0;
        check("overrun_set", 64'(ovr), 64'd1);
`ifdef SCHED_OVERRUN_RESTART_EN
        check("restart_valid", 64'(valid), 64'd0);
        check("restart_index1", 64'(idx1), 64'd0);
        check("restart_index2", 64'(idx2), 64'(SR));
        check("restart_slice", 64'(sidx), 64'((s0 + 2) % NS));
`else
        check("ignore_slice", 64'(sidx), 64'((s0 + 1) % NS));
`endif
        run_until_done(200, n);
        check("overrun_line", 64'(line), 64'(SR - 1));
        check("overrun_done_count", 64'(n_done), 64'd1);
        check("overrun_sticky", 64'(ovr), 64'd1);

        // Back-to-back slices: slice index wraps
        do_reset();
        ready = 1;
        for (int s = 0; s < NS; s++) begin
            tick = 1;
            step();
            tick = 0;
            check("wrap_slice", 64'(sidx), 64'((s + 1) % NS));
            run_until_done(200, n);
        end
        check("wrap_zero", 64'(sidx), 64'd0);

        // Reset while presenting pair 20, then restart
        tick = 1; ready = 1;
        step();
        tick = 0;
        run_until_line(20, 100);
        do_reset();
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cols", 64'(cols_out == '0), 64'd1);
        tick = 1; ready = 1;
        step();
        tick = 0;
        check("post_rst_index1", 64'(idx1), 64'd0);
        check("post_rst_index2", 64'(idx2), 64'(SR));
        check("post_rst_slice", 64'(sidx), 64'd1);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                tick = ($urandom_range(0, 79) == 0);
                ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_column_pair_scheduler
`default_nettype wire
